// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one pipelined multi-operand adder among
// NREQ requesters, with an in-order tag FIFO routing each sum back to its owner.
module adder_arbiter #(
    parameter int NREQ    = 3,
    parameter int BITS    = 16,
    parameter int NUM     = 4,
    parameter int MAX_OUT = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*NUM*BITS-1:0] req_data,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [BITS-1:0]          rsp_data,
    output logic                     add_valid,
    output logic [NUM*BITS-1:0]      add_i,
    input  logic [BITS-1:0]          add_o,
    input  logic                     add_valid_out,
    output logic                     busy,
    output logic                     err_underflow
);
    localparam int SET_W = NUM * BITS;
    localparam int ID_W  = $clog2(NREQ);
    localparam int AW    = $clog2(MAX_OUT);
    localparam int CW    = $clog2(MAX_OUT + 1);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);
    localparam logic [CW-1:0]   FULL    = CW'(MAX_OUT);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] cand;
    logic            found;
    logic            can_issue;
    logic            push;
    logic            pop;
    logic [CW-1:0]   outstanding;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [ID_W-1:0] tag_mem [MAX_OUT];
    logic [ID_W-1:0] pop_tag;
    logic [NREQ-1:0] rsp_valid_d;

    // Search upward from the requester after the last winner, wrapping at NREQ-1.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        found  = 1'b0;
        winner = '0;
        cand   = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Credit check uses the registered count only; a same-cycle pop frees nothing yet.
    assign can_issue = found && (outstanding < FULL);
    assign push      = can_issue;
    assign pop       = add_valid_out && (outstanding != '0);
    assign pop_tag   = tag_mem[rd_ptr];
    assign busy      = (outstanding != '0) || add_valid;

    always_comb begin
        req_ready         = '0;
        req_ready[winner] = can_issue;
    end

    always_comb begin
        rsp_valid_d = '0;
        if (pop) begin
            rsp_valid_d[pop_tag] = 1'b1;
        end
    end

    // NOTE: tag storage has no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= winner;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr        <= LAST_ID;
            outstanding   <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            add_valid     <= 1'b0;
            add_i         <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            err_underflow <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples pre-edge values in any statement order.
            add_valid <= push;
            if (push) begin
                add_i  <= req_data[winner*SET_W +: SET_W];
                rr_ptr <= winner;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                rsp_data <= add_o;
            end
            outstanding <= outstanding + CW'(push) - CW'(pop);
            rsp_valid   <= rsp_valid_d;
            if (add_valid_out && (outstanding == '0)) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed self-checking bench for adder_arbiter with a
// behavioural fixed-latency adder (stall and result injection controls).
module tb_adder_arbiter;
    localparam int NREQ = 3;
    localparam int BITS = 16;
    localparam int NUM  = 4;
    localparam int LAT  = 4;

    logic                     clk = 1'b0;
    logic                     resetn = 1'b0;
    logic [NREQ-1:0]          req_valid = '0;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*NUM*BITS-1:0] req_data = '0;
    logic [NREQ-1:0]          rsp_valid;
    logic [BITS-1:0]          rsp_data;
    logic                     add_valid;
    logic [NUM*BITS-1:0]      add_i;
    logic [BITS-1:0]          add_o = '0;
    logic                     add_valid_out = 1'b0;
    logic                     busy;
    logic                     err_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    adder_arbiter #(.NREQ(NREQ), .BITS(BITS), .NUM(NUM), .MAX_OUT(8)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .add_valid(add_valid), .add_i(add_i), .add_o(add_o), .add_valid_out(add_valid_out),
        .busy(busy), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BITS-1:0] sum4(input logic [63:0] v);
        return v[63:48] + v[47:32] + v[31:16] + v[15:0];
    endfunction

    // Behavioural adder: results appear LAT steps after issue unless stalled.
    logic [BITS-1:0] sum_q[$];
    int              iss_q[$];
    int              cyc = 0;
    bit              stall = 0;
    bit              inj = 0;
    logic [BITS-1:0] inj_val = '0;

    always @(posedge clk) begin
        #2;
        cyc++;
        add_valid_out = 1'b0;
        if (!resetn) begin
            sum_q.delete();
            iss_q.delete();
        end else begin
            if (add_valid) begin
                sum_q.push_back(sum4(add_i));
                iss_q.push_back(cyc);
            end
            if (inj) begin
                add_valid_out = 1'b1;
                add_o = inj_val;
            end else if (!stall && iss_q.size() > 0 && (cyc - iss_q[0]) >= LAT) begin
                add_valid_out = 1'b1;
                add_o = sum_q.pop_front();
                void'(iss_q.pop_front());
            end
        end
    end

    // Response log consumed by the tests.
    logic [NREQ-1:0] rsp_vec_q[$];
    logic [BITS-1:0] rsp_dat_q[$];

    always @(posedge clk) begin
        #3;
        if (rsp_valid != '0) begin
            rsp_vec_q.push_back(rsp_valid);
            rsp_dat_q.push_back(rsp_data);
        end
    end

    task automatic do_reset();
        req_valid = '0;
        stall = 0;
        inj = 0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        rsp_vec_q.delete();
        rsp_dat_q.delete();
    endtask

    task automatic wait_rsp(input int n, input int budget, input string tag);
        int c = 0;
        while (rsp_vec_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (10) @(negedge clk);
        check(tag, 64'(rsp_vec_q.size()), 64'(n));
    endtask

    int cnt;
    int k;
    int guard;
    int bad;
    int gcnt[NREQ];
    int exp_order[6] = '{0, 1, 2, 0, 1, 2};
    logic [NREQ-1:0] exp_vec[6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [BITS-1:0] exp_dat[6] = '{16'h1001, 16'h1002, 16'h1003, 16'h1002, 16'h1003, 16'h1004};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        #1;
        check("rst_add_valid", add_valid, 0);
        check("rst_add_i", add_i, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_err", err_underflow, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);

        // 1. Single request from requester 1
        @(negedge clk);
        req_valid = 3'b010;
        req_data[1*64 +: 64] = 64'h8298_3c5f_fda9_e623;
        #1;
        check("t1_ready", req_ready, 3'b010);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("t1_ready_drop", req_ready, 0);
        check("t1_add_valid", add_valid, 1);
        check("t1_add_i", add_i, 64'h8298_3c5f_fda9_e623);
        check("t1_busy", busy, 1);
        wait_rsp(1, 20, "t1_rsp_count");
        if (rsp_vec_q.size() >= 1) begin
            check("t1_rsp_valid", rsp_vec_q[0], 3'b010);
            check("t1_rsp_data", rsp_dat_q[0], 16'ha2c3);
        end
        check("t1_busy_idle", busy, 0);

        // 2. Round-robin with all requesters active
        do_reset();
        for (int r = 0; r < NREQ; r++) gcnt[r] = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = 3'b111;
            for (int r = 0; r < NREQ; r++)
                req_data[r*64 +: 64] = {16'(r + 1), 16'(gcnt[r]), 16'h1000, 16'h0000};
            #1;
            check($sformatf("t2_grant%0d", c), req_ready, 64'(3'b001 << exp_order[c]));
            for (int r = 0; r < NREQ; r++) if (req_ready[r]) gcnt[r]++;
        end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(6, 30, "t2_rsp_count");
        if (rsp_vec_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("t2_rsp_vec%0d", i), rsp_vec_q[i], exp_vec[i]);
                check($sformatf("t2_rsp_dat%0d", i), rsp_dat_q[i], exp_dat[i]);
            end
        end

        // 3. Credit limit with the adder stalled
        do_reset();
        stall = 1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            req_valid = 3'b001;
            req_data[0 +: 64] = {16'(cnt), 48'h0};
            #1;
            if (req_ready[0]) cnt++;
        end
        check("t3_transfers", 64'(cnt), 8);
        check("t3_ready_full", req_ready, 0);
        check("t3_busy", busy, 1);
        @(negedge clk);
        stall = 0;
        #1;
        check("t3_ready_still_full", req_ready, 0);
        @(negedge clk);
        #1;
        check("t3_first_pop", add_valid_out, 1);
        check("t3_ready_on_pop", req_ready, 0);
        @(negedge clk);
        req_data[0 +: 64] = {16'(cnt), 48'h0};
        #1;
        check("t3_ready_after_pop", req_ready, 3'b001);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(9, 60, "t3_rsp_count");
        bad = 0;
        for (int i = 0; i < rsp_dat_q.size(); i++)
            if (rsp_dat_q[i] !== 16'(i) || rsp_vec_q[i] !== 3'b001) bad++;
        check("t3_rsp_errors", 64'(bad), 0);

        // 4. Steady streaming: push and pop every cycle at outstanding = 5
        do_reset();
        k = 0;
        guard = 0;
        while (k < 50 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (k >= 5) check($sformatf("t4_outstanding_k%0d", k), 64'(dut.outstanding), 5);
            req_valid = 3'b001;
            req_data[0 +: 64] = {16'(k), 16'h0100, 32'h0};
            #1;
            if (req_ready[0]) k++;
        end
        check("t4_issued", 64'(k), 50);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(50, 100, "t4_rsp_count");
        bad = 0;
        for (int i = 0; i < rsp_dat_q.size(); i++)
            if (rsp_dat_q[i] !== 16'(16'h0100 + i) || rsp_vec_q[i] !== 3'b001) bad++;
        check("t4_rsp_errors", 64'(bad), 0);

        // 5. Underflow with an idle arbiter
        do_reset();
        @(negedge clk);
        inj = 1;
        inj_val = 16'hdead;
        @(negedge clk);
        inj = 0;
        @(negedge clk);
        #1;
        check("t5_err", err_underflow, 1);
        check("t5_busy", busy, 0);
        repeat (5) @(negedge clk);
        #1;
        check("t5_err_sticky", err_underflow, 1);
        check("t5_busy_idle", busy, 0);
        check("t5_no_rsp", 64'(rsp_vec_q.size()), 0);

        // 6. Reset with four additions in flight
        do_reset();
        stall = 1;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = 3'b111;
            #1;
            if (req_ready != '0) cnt++;
        end
        check("t6_inflight", 64'(cnt), 4);
        @(negedge clk);
        #1;
        check("t6_busy_before", busy, 1);
        check("t6_add_valid_before", add_valid, 1);
        #1;
        resetn = 1'b0;
        req_valid = '0;
        #1;
        check("t6_async_add_valid", add_valid, 0);
        check("t6_async_add_i", add_i, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_rsp_valid", rsp_valid, 0);
        check("t6_async_err", err_underflow, 0);
        @(negedge clk);
        stall = 0;
        resetn = 1'b1;
        rsp_vec_q.delete();
        rsp_dat_q.delete();
        req_valid = 3'b111;
        req_data[0 +: 64] = 64'h0001_0002_0003_0004;
        #1;
        check("t6_first_grant", req_ready, 3'b001);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(1, 20, "t6_rsp_count");
        if (rsp_vec_q.size() >= 1) begin
            check("t6_rsp_valid", rsp_vec_q[0], 3'b001);
            check("t6_rsp_data", rsp_dat_q[0], 16'h000a);
        end
        check("t6_err_clear", err_underflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Round-robin arbiter that shares one pipelined multi-input adder among NREQ requesters.
- Each requester presents one packed operand set through a valid/ready handshake. The arbiter issues granted sets to the adder and tags each issue with the requester ID in an in-order tag FIFO.
- On each adder valid_out, the arbiter pops the tag and routes the sum back to the owning requester.
- Sits between client logic and the adder instance; the adder itself is unchanged.

Parameters:
- NREQ, 3, number of requesters (2..8).
- BITS, 16, operand and result width.
- NUM, 4, operands per addition.
- MAX_OUT, 8, maximum additions in flight; this is also the tag FIFO depth (power of 2).

Ports:
- clk  input  1  clock.
- resetn  input  1  reset.
- req_valid  input  NREQ  per-requester operand set valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_data  input  NREQ*NUM*BITS  operand sets; requester r occupies slice r; within a slice, i0 is in the MSBs.
- rsp_valid  output  NREQ  one-cycle result pulse, one-hot or zero.
- rsp_data  output  BITS  result; shared by all requesters, qualified by rsp_valid.
- add_valid  output  1  issue strobe to the adder.
- add_i  output  NUM*BITS  packed operands to the adder, i0 in the MSBs.
- add_o  input  BITS  adder sum.
- add_valid_out  input  1  adder result valid.
- busy  output  1  high while outstanding != 0 or add_valid == 1.
- err_underflow  output  1  sticky; set by add_valid_out while the tag FIFO is empty.

Behaviour:
- Reset (asynchronous, active-low on resetn, clock clk):
  - add_valid, add_i, rsp_valid, rsp_data, err_underflow and the outstanding count all reset to 0.
  - The round-robin pointer resets to NREQ-1, so requester 0 has first priority.
  - The tag FIFO is emptied.
- Grant (combinational, within the cycle):
  - Condition: can_issue = (outstanding < MAX_OUT) and any req_valid.
  - Winner: the first requester with req_valid set, searching upward (with wrap) from pointer+1.
  - req_ready[winner] = can_issue; all other req_ready bits are 0.
  - A transfer occurs when req_valid[r] and req_ready[r] are both 1.
- Issue (registered):
  - On a transfer, add_valid = 1 on the next cycle and add_i = req_data slice of the winner.
  - Otherwise add_valid = 0 and add_i holds its last value.
  - The pointer updates to the winner only on a transfer.
  - The winner ID is pushed into the tag FIFO in the same transfer cycle.
- Back-to-back operation: one issue per cycle is sustained while credits remain.
  - A requester holding req_valid continuously while others are idle is granted every cycle.
  - With several requesters active, grants rotate strictly: 0,1,2,0,...
- Credits:
  - outstanding increments on a transfer and decrements on add_valid_out.
  - A simultaneous transfer and add_valid_out leaves outstanding unchanged; the FIFO push and pop both occur.
  - At outstanding == MAX_OUT, req_ready is 0 for all requesters. A pop in the same cycle does not free a credit until the next cycle, so the full condition is registered only.
- Response (registered, 1 cycle after add_valid_out):
  - rsp_valid[tag] = 1 and rsp_data = add_o, using the tag popped from the FIFO.
  - There is no response back-pressure; requesters must always accept.
- Underflow:
  - If add_valid_out arrives with the FIFO empty, there is no pop and no rsp_valid.
  - err_underflow is set and held until reset.
  - outstanding saturates at 0.
- Ordering: the adder returns results in issue order with any fixed latency; no latency parameter is needed.
- Arithmetic: the sum is modulo 2^BITS and is computed by the adder only; the arbiter never modifies data.
- Reset mid-operation: all in-flight tags are discarded. Results that arrive after reset deassertion with an empty FIFO flag err_underflow; the environment resets the adder together with the arbiter.
- A req_valid deasserted before a grant is allowed and has no effect.

Test Plan:
1. Single request:
   - Stimulus: requester 1 sends {8298,3c5f,fda9,e623}.
   - Required: req_ready[1]=1 for one cycle, then add_valid=1 and add_i=0x82983c5ffda9e623. After the adder latency+1, rsp_valid=3'b010 and rsp_data=0xa2c3.
2. Round-robin:
   - Stimulus: all 3 requesters hold valid for 6 cycles.
   - Required: grant order 0,1,2,0,1,2. Each requester receives 2 responses, in order and tagged correctly.
3. Credit limit:
   - Stimulus: MAX_OUT=8 with the adder held stalled (valid_out suppressed), requester 0 streaming.
   - Required: exactly 8 transfers, after which req_ready=0. The first valid_out frees one credit, and the next transfer occurs on the following cycle.
4. Simultaneous push and pop:
   - Stimulus: steady streaming at outstanding=5 with valid_out every cycle.
   - Required: outstanding stays at 5, with no lost or duplicated responses over 50 additions.
5. Underflow:
   - Stimulus: inject add_valid_out with an idle arbiter.
   - Required: err_underflow=1 sticky, rsp_valid stays 0, busy stays 0.
6. Reset mid-stream:
   - Stimulus: assert resetn low with 4 additions in flight.
   - Required: all outputs go to 0 immediately (asynchronously) and the pointer returns to NREQ-1. After release, the first grant goes to requester 0.
